// File: rtl/riscv_pkg.sv
// Shared RISC-V core types used by the branch feedback path.
//   BranchOutcome : resolved branch direction as seen by the fetch predictors.
package riscv_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

endpackage

// File: rtl/branch_fb_gen_if.sv
// Branch feedback bus between the execute-stage branch units, the feedback
// generator and the fetch-stage predictors.
//   res_*    : up to two resolved branches per cycle, slot 0 older
//   res_ready: generator can take both slots this cycle
//   fb_hold  : predictor side cannot accept feedback this cycle
//   o_fb_*   : up to two feedback slots per cycle, slot 0 older
// master = environment (branch units + predictors), slave = branch_fb_gen.
interface branch_fb_gen_if #(
  parameter int ADDR_WIDTH = 32
);

  logic [1:0]                              res_valid;
  logic [1:0][ADDR_WIDTH-1:0]              res_pc;
  logic [1:0]                              res_taken;
  logic [1:0][ADDR_WIDTH-1:0]              res_target;
  logic [1:0]                              res_mispredict;
  logic                                    res_ready;
  logic                                    fb_hold;
  logic [1:0]                              o_fb_if_branch;
  logic [1:0][ADDR_WIDTH-1:0]              o_fb_branch_pc;
  riscv_pkg::BranchOutcome [1:0]           o_fb_outcome;
  logic [1:0][ADDR_WIDTH-1:0]              o_fb_target;
  logic [1:0]                              o_fb_mispredict;

  modport master (
    output res_valid, res_pc, res_taken, res_target, res_mispredict, fb_hold,
    input  res_ready, o_fb_if_branch, o_fb_branch_pc, o_fb_outcome,
           o_fb_target, o_fb_mispredict
  );

  modport slave (
    input  res_valid, res_pc, res_taken, res_target, res_mispredict, fb_hold,
    output res_ready, o_fb_if_branch, o_fb_branch_pc, o_fb_outcome,
           o_fb_target, o_fb_mispredict
  );

endinterface

// File: rtl/branch_fb_gen.sv
// Branch feedback generator: buffers resolved branches from two branch units
// in an in-order circular FIFO and drains up to two per cycle to the fetch
// predictors.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   flush          : drop all buffered and incoming entries
//   fb (slave)     : resolved-branch input + feedback output bus
//   mispredict_cnt : saturating count of emitted mispredicts
//   overflow_err   : sticky, input seen while res_ready was low

// One feedback output slot: gates the head entry onto the bus, zero when idle.
module branch_fb_lane #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    vld,
  input  logic [ADDR_WIDTH-1:0]   pc,
  input  logic                    taken,
  input  logic [ADDR_WIDTH-1:0]   target,
  input  logic                    mispredict,
  output logic                    if_branch,
  output logic [ADDR_WIDTH-1:0]   o_pc,
  output riscv_pkg::BranchOutcome outcome,
  output logic [ADDR_WIDTH-1:0]   o_target,
  output logic                    o_mispredict
);

  assign if_branch    = vld;
  assign o_pc         = vld ? pc : '0;
  assign o_target     = vld ? target : '0;
  assign o_mispredict = vld & mispredict;
  assign outcome      = (vld && taken) ? riscv_pkg::TAKEN : riscv_pkg::NOT_TAKEN;

endmodule

module branch_fb_gen #(
  parameter int DEPTH        = 8,
  parameter int FB_PER_CYCLE = 2,
  parameter int CNT_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  branch_fb_gen_if.slave       fb,
  output logic [CNT_WIDTH-1:0] mispredict_cnt,
  output logic                 overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] READY_MAX = (PW+1)'(DEPTH - 2);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;
    logic                  mispredict;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count, count_next;

  entry_t        wr_e [2];
  entry_t        rd_e [2];
  logic [1:0]    lane_vld;
  logic          push_ok;
  logic [1:0]    push_n, pop_n, mp_add;
  logic [PW-1:0] wr_idx1;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_next;

  // Ready looks only at the registered fill level so the branch units never
  // see a path through fb_hold or the pop logic.
  assign fb.res_ready = (count <= READY_MAX);

  assign push_ok = fb.res_ready && !flush;
  assign push_n  = push_ok ? ({1'b0, fb.res_valid[0]} + {1'b0, fb.res_valid[1]}) : 2'd0;
  // Compaction: slot 1 lands at tail when slot 0 is empty.
  assign wr_idx1 = tail + PW'(fb.res_valid[0]);

  assign lane_vld[0] = (count != '0) && !fb.fb_hold && !flush;
  assign lane_vld[1] = (FB_PER_CYCLE == 2) && (count >= (PW+1)'(2)) &&
                       !fb.fb_hold && !flush;

  genvar i;
  generate
    for (i = 0; i < 2; i++) begin : g_lane
      assign wr_e[i] = '{pc:         fb.res_pc[i],
                         taken:      fb.res_taken[i],
                         target:     fb.res_target[i],
                         mispredict: fb.res_mispredict[i]};
      assign rd_e[i] = mem[head + PW'(i)];

      branch_fb_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
        .vld          (lane_vld[i]),
        .pc           (rd_e[i].pc),
        .taken        (rd_e[i].taken),
        .target       (rd_e[i].target),
        .mispredict   (rd_e[i].mispredict),
        .if_branch    (fb.o_fb_if_branch[i]),
        .o_pc         (fb.o_fb_branch_pc[i]),
        .outcome      (fb.o_fb_outcome[i]),
        .o_target     (fb.o_fb_target[i]),
        .o_mispredict (fb.o_fb_mispredict[i])
      );
    end
  endgenerate

  // Consumer takes everything offered whenever it is not holding.
  assign pop_n  = {1'b0, fb.o_fb_if_branch[0]} + {1'b0, fb.o_fb_if_branch[1]};
  assign mp_add = {1'b0, fb.o_fb_mispredict[0]} + {1'b0, fb.o_fb_mispredict[1]};

  assign count_next = count + (PW+1)'(push_n) - (PW+1)'(pop_n);

  // One extra bit catches the carry; on carry clamp to all-ones.
  assign cnt_sum  = {1'b0, mispredict_cnt} + (CNT_WIDTH+1)'(mp_add);
  assign cnt_next = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      mispredict_cnt <= '0;
      overflow_err   <= 1'b0;
    end else begin
      if (!fb.res_ready && (fb.res_valid != 2'b00))
        overflow_err <= 1'b1;
      mispredict_cnt <= cnt_next;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + PW'(pop_n);
        tail  <= tail + PW'(push_n);
        count <= count_next;
      end
    end
  end

  // Payload storage carries no reset; validity lives in count/head.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      if (fb.res_valid[0]) mem[tail]    <= wr_e[0];
      if (fb.res_valid[1]) mem[wr_idx1] <= wr_e[1];
    end
  end

endmodule

// File: tb/tb_branch_fb_gen.sv
module tb_branch_fb_gen;

  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [3:0] mispredict_cnt;
  logic overflow_err;

  int n_pass = 0;
  int n_total = 0;

  branch_fb_gen_if #(.ADDR_WIDTH(AW)) bus ();

  branch_fb_gen #(
    .DEPTH(8), .FB_PER_CYCLE(2), .CNT_WIDTH(4), .ADDR_WIDTH(AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .fb             (bus),
    .mispredict_cnt (mispredict_cnt),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1);
  end

  task automatic clr_in();
    bus.res_valid      = '0;
    bus.res_pc         = '0;
    bus.res_taken      = '0;
    bus.res_target     = '0;
    bus.res_mispredict = '0;
  endtask

  task automatic set_slot(input int s, input logic [AW-1:0] pc, input logic tk, input logic mp);
    bus.res_valid[s]      = 1'b1;
    bus.res_pc[s]         = pc;
    bus.res_taken[s]      = tk;
    bus.res_target[s]     = pc + 32'h40;
    bus.res_mispredict[s] = mp;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; bus.fb_hold = 1'b0; clr_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++; if (bus.res_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.res_ready); else n_pass++;
    n_total++; if (bus.o_fb_if_branch !== 2'b00) $display("FAIL reset_valid got %b want 00", bus.o_fb_if_branch); else n_pass++;
    n_total++; if (mispredict_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", mispredict_cnt); else n_pass++;
    n_total++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow_err); else n_pass++;
  endtask

  task automatic test_pair();
    set_slot(0, 32'h100, 1'b1, 1'b0);
    set_slot(1, 32'h104, 1'b0, 1'b0);
    #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b00) $display("FAIL pair_no_bypass got %b want 00", bus.o_fb_if_branch); else n_pass++;
    cyc(); clr_in(); #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b11) $display("FAIL pair_valid got %b want 11", bus.o_fb_if_branch); else n_pass++;
    n_total++; if (bus.o_fb_branch_pc[0] !== 32'h100 || bus.o_fb_outcome[0] !== riscv_pkg::TAKEN)
      $display("FAIL pair_slot0 got pc %h out %b want 100/1", bus.o_fb_branch_pc[0], bus.o_fb_outcome[0]); else n_pass++;
    n_total++; if (bus.o_fb_branch_pc[1] !== 32'h104 || bus.o_fb_outcome[1] !== riscv_pkg::NOT_TAKEN)
      $display("FAIL pair_slot1 got pc %h out %b want 104/0", bus.o_fb_branch_pc[1], bus.o_fb_outcome[1]); else n_pass++;
    n_total++; if (bus.o_fb_target[1] !== 32'h144) $display("FAIL pair_target got %h want 144", bus.o_fb_target[1]); else n_pass++;
    cyc(); #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b00 || bus.res_ready !== 1'b1)
      $display("FAIL pair_empty got vld %b rdy %b want 00/1", bus.o_fb_if_branch, bus.res_ready); else n_pass++;
  endtask

  task automatic test_compact();
    set_slot(1, 32'h200, 1'b1, 1'b0);
    cyc(); clr_in(); #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b01 || bus.o_fb_branch_pc[0] !== 32'h200 || bus.o_fb_branch_pc[1] !== 32'h0)
      $display("FAIL compact got vld %b pc0 %h pc1 %h want 01/200/0",
               bus.o_fb_if_branch, bus.o_fb_branch_pc[0], bus.o_fb_branch_pc[1]); else n_pass++;
    cyc(); #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b00) $display("FAIL compact_empty got %b want 00", bus.o_fb_if_branch); else n_pass++;
  endtask

  // Entry e: pc 0x300+4e, taken when e is even.
  task automatic test_hold_fill();
    logic [1:0] want_v;
    bus.fb_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_slot(0, 32'h300 + 32'(8*k),     1'b1, 1'b0);
      set_slot(1, 32'h300 + 32'(8*k + 4), 1'b0, 1'b0);
      cyc();
    end
    clr_in(); #1;
    n_total++; if (bus.res_ready !== 1'b1) $display("FAIL fill_ready6 got %b want 1", bus.res_ready); else n_pass++;
    set_slot(0, 32'h318, 1'b1, 1'b0);
    cyc(); clr_in(); #1;
    n_total++; if (bus.res_ready !== 1'b0) $display("FAIL fill_ready7 got %b want 0", bus.res_ready); else n_pass++;
    n_total++; if (bus.o_fb_if_branch !== 2'b00) $display("FAIL fill_hold got %b want 00", bus.o_fb_if_branch); else n_pass++;
    set_slot(0, 32'h3F0, 1'b1, 1'b0);
    set_slot(1, 32'h3F4, 1'b1, 1'b0);
    cyc(); clr_in(); #1;
    n_total++; if (overflow_err !== 1'b1) $display("FAIL overflow_set got %b want 1", overflow_err); else n_pass++;
    n_total++; if (bus.res_ready !== 1'b0) $display("FAIL overflow_ready got %b want 0", bus.res_ready); else n_pass++;
    bus.fb_hold = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      want_v = (c < 3) ? 2'b11 : 2'b01;
      n_total++;
      if (bus.o_fb_if_branch !== want_v || bus.o_fb_branch_pc[0] !== 32'h300 + 32'(8*c) ||
          bus.o_fb_outcome[0] !== riscv_pkg::TAKEN ||
          (c < 3 && bus.o_fb_branch_pc[1] !== 32'h300 + 32'(8*c + 4)))
        $display("FAIL drain_%0d got vld %b pc0 %h pc1 %h want %b/%h/%h", c, bus.o_fb_if_branch,
                 bus.o_fb_branch_pc[0], bus.o_fb_branch_pc[1], want_v, 32'h300 + 32'(8*c), 32'h300 + 32'(8*c + 4));
      else n_pass++;
      cyc();
    end
    #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b00 || bus.res_ready !== 1'b1)
      $display("FAIL drain_empty got vld %b rdy %b want 00/1", bus.o_fb_if_branch, bus.res_ready); else n_pass++;
  endtask

  // Sequence n: pc 0x1000+4n.
  task automatic test_steady();
    bus.fb_hold = 1'b1;
    set_slot(0, 32'h1000, 1'b0, 1'b0);
    set_slot(1, 32'h1004, 1'b1, 1'b0);
    cyc();
    bus.fb_hold = 1'b0;
    for (int j = 0; j < 20; j++) begin
      set_slot(0, 32'h1000 + 32'(4*(2*j + 2)), 1'b0, 1'b0);
      set_slot(1, 32'h1000 + 32'(4*(2*j + 3)), 1'b1, 1'b0);
      #1;
      n_total++;
      if (bus.o_fb_if_branch !== 2'b11 || bus.res_ready !== 1'b1 ||
          bus.o_fb_branch_pc[0] !== 32'h1000 + 32'(8*j) || bus.o_fb_branch_pc[1] !== 32'h1000 + 32'(8*j + 4))
        $display("FAIL steady_%0d got vld %b pc0 %h pc1 %h want 11/%h/%h", j, bus.o_fb_if_branch,
                 bus.o_fb_branch_pc[0], bus.o_fb_branch_pc[1], 32'h1000 + 32'(8*j), 32'h1000 + 32'(8*j + 4));
      else n_pass++;
      cyc();
    end
    clr_in(); #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b11 || bus.o_fb_branch_pc[0] !== 32'h10A0 || bus.o_fb_branch_pc[1] !== 32'h10A4)
      $display("FAIL steady_tail got vld %b pc0 %h pc1 %h want 11/10a0/10a4",
               bus.o_fb_if_branch, bus.o_fb_branch_pc[0], bus.o_fb_branch_pc[1]); else n_pass++;
    cyc(); #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b00) $display("FAIL steady_empty got %b want 00", bus.o_fb_if_branch); else n_pass++;
  endtask

  task automatic test_flush();
    bus.fb_hold = 1'b1;
    set_slot(0, 32'h500, 1'b1, 1'b0); set_slot(1, 32'h504, 1'b1, 1'b0); cyc();
    set_slot(0, 32'h508, 1'b1, 1'b0); set_slot(1, 32'h50C, 1'b1, 1'b0); cyc();
    clr_in();
    set_slot(0, 32'h510, 1'b1, 1'b0); cyc();
    flush = 1'b1; bus.fb_hold = 1'b0;
    set_slot(0, 32'h5F0, 1'b1, 1'b1); set_slot(1, 32'h5F4, 1'b1, 1'b1);
    #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b00) $display("FAIL flush_cycle got %b want 00", bus.o_fb_if_branch); else n_pass++;
    cyc(); flush = 1'b0; clr_in(); #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b00 || bus.res_ready !== 1'b1)
      $display("FAIL flush_after got vld %b rdy %b want 00/1", bus.o_fb_if_branch, bus.res_ready); else n_pass++;
    n_total++; if (overflow_err !== 1'b1 || mispredict_cnt !== 4'd0)
      $display("FAIL flush_stats got ovf %b cnt %0d want 1/0", overflow_err, mispredict_cnt); else n_pass++;
    set_slot(0, 32'h600, 1'b1, 1'b0);
    cyc(); clr_in(); #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b01 || bus.o_fb_branch_pc[0] !== 32'h600)
      $display("FAIL flush_fresh got vld %b pc0 %h want 01/600", bus.o_fb_if_branch, bus.o_fb_branch_pc[0]); else n_pass++;
    cyc();
  endtask

  // Row i: mispredicts pushed at edge i, counter value after edge i
  // (entries pushed at edge i-1 are popped and counted at edge i).
  task automatic test_mispredict();
    int push_mp [11] = '{2, 1, 1, 2, 2, 2, 2, 2, 2, 2, 0};
    int exp_cnt [11] = '{0, 2, 3, 4, 6, 8, 10, 12, 14, 15, 15};
    logic [1:0] want_mp;
    for (int i = 0; i < 11; i++) begin
      if (push_mp[i] >= 1) set_slot(0, 32'h700 + 32'(8*i),     1'b1, 1'b1);
      if (push_mp[i] >= 1) set_slot(1, 32'h700 + 32'(8*i + 4), 1'b0, push_mp[i] == 2);
      cyc(); clr_in(); #1;
      want_mp = (push_mp[i] == 2) ? 2'b11 : (push_mp[i] == 1) ? 2'b01 : 2'b00;
      n_total++; if (mispredict_cnt !== 4'(exp_cnt[i]))
        $display("FAIL mp_cnt_%0d got %0d want %0d", i, mispredict_cnt, exp_cnt[i]); else n_pass++;
      n_total++; if (bus.o_fb_mispredict !== want_mp)
        $display("FAIL mp_flag_%0d got %b want %b", i, bus.o_fb_mispredict, want_mp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bus.fb_hold = 1'b1;
    set_slot(0, 32'h800, 1'b1, 1'b1); set_slot(1, 32'h804, 1'b1, 1'b1);
    cyc(); clr_in();
    reset = 1'b1;
    cyc();
    reset = 1'b0; bus.fb_hold = 1'b0; #1;
    n_total++; if (bus.o_fb_if_branch !== 2'b00 || bus.res_ready !== 1'b1)
      $display("FAIL rst_mid_fifo got vld %b rdy %b want 00/1", bus.o_fb_if_branch, bus.res_ready); else n_pass++;
    n_total++; if (mispredict_cnt !== 4'd0 || overflow_err !== 1'b0)
      $display("FAIL rst_mid_stats got cnt %0d ovf %b want 0/0", mispredict_cnt, overflow_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pair();
    test_compact();
    test_hold_fill();
    test_steady();
    test_flush();
    test_mispredict();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
